ehl_ahb_mem_slave: RTL and testbench
====================================

EHL_AHB_MEM_SLAVE -- requirements
Module: ehl_ahb_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words; power of 2, minimum 4.
REQ-002 SHALL have parameter MEM_BASE, default 32'h00000000, meaning the byte address that maps to word 0.
REQ-003 SHALL have port hclk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port hreset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have inputs hsel (1), hready_in (1), htrans (2), hwrite (1), hsize (3), haddr (32) and hwdata (32): the AHB address- and data-phase inputs from the matrix.
REQ-006 SHALL have outputs hready (1), hresp (2) and hrdata (32): the AHB response to the matrix.
REQ-007 SHALL have input resp_delay, 8 bits: number of wait states inserted per OKAY transfer, sampled at address-phase acceptance.

Function
REQ-008 SHALL accept a transfer when hsel & hready_in & htrans[1] are all 1 at a rising edge; IDLE/BUSY (htrans[1]=0) or hsel=0 gives a zero-wait OKAY.
REQ-009 SHALL classify an accepted transfer as ERROR if any of these hold: hsize>2; haddr misaligned for hsize; (haddr-MEM_BASE) >= DEPTH*4.
REQ-010 SHALL implement FSM states IDLE, WAIT, ERR1 and ERR2 with these transitions:
- IDLE->WAIT: on an OKAY accept with resp_delay>0.
- IDLE->IDLE: on an OKAY accept with resp_delay=0.
- IDLE->ERR1: on an error accept.
- WAIT->IDLE: after resp_delay cycles.
- ERR1->ERR2 unconditionally; ERR2->IDLE unconditionally.
REQ-011 SHALL drive the following per state:
- WAIT: hready=0, hresp=0.
- ERR1: hready=0, hresp=1.
- ERR2: hready=1, hresp=1.
- IDLE (OKAY data phase or no transfer): hready=1, hresp=0.
REQ-012 SHALL, in ERR2, accept a new address phase presented that cycle exactly as IDLE would; an ERROR transfer SHALL never modify memory.
REQ-013 SHALL capture haddr, hsize and hwrite at acceptance and write hwdata into the addressed word in the final data-phase cycle (hready=1), using byte lanes as follows:
- Byte: lane haddr[1:0].
- Halfword: lanes 2*haddr[1] and 2*haddr[1]+1.
- Word: all four lanes.
REQ-014 SHALL present read data on hrdata, full 32-bit word with no lane masking, in the data-phase cycle where hready=1, i.e. latency of 1+resp_delay cycles after acceptance.
REQ-015 SHALL forward write data to a read whose address phase coincides with a pending write data phase to the same word, merging written lanes over stored lanes, so a back-to-back write->read returns the new value.
REQ-016 SHALL ignore htrans/haddr while hready=0; pipelined address phases are accepted only in a cycle with hready=1.
REQ-017 SHALL compute word index as (haddr-MEM_BASE)>>2 truncated to log2(DEPTH) bits after the range check; no wrap-around aliasing.
REQ-018 SHALL hold hrdata at its last value outside read data phases.

Reset
REQ-019 SHALL, with hreset=1 at a rising edge, force state IDLE, hready=1, hresp=0, hrdata=0 and cancel any in-flight transfer without writing memory.
REQ-020 SHALL leave memory contents unchanged by reset.
REQ-021 SHALL behave per REQ-019 when reset is asserted mid-WAIT or mid-ERR1: hready=1 on the next cycle.

Structure
REQ-022 SHALL take the HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), the HRESP codes (OKAY=0, ERROR=1) and the FSM state encodings from the shared AHB package ehl_ahb_pkg.
REQ-023 SHALL instantiate one sub-module, ehl_ahb_mem_bytelane, holding the DEPTH x 32 array with 4-bit byte-write enable, synchronous write and combinational read.

Verification
REQ-024 SHALL cover word write then read: write 32'hA5A5_1234 at MEM_BASE+8, resp_delay=0, then read MEM_BASE+8 -> hrdata=32'hA5A5_1234, hready never low.
REQ-025 SHALL cover byte write: word at 0x4 = 32'h11223344, write byte 32'hxxxx_EExx to MEM_BASE+5 (hsize=0) -> read word 0x4 = 32'h1122EE44.
REQ-026 SHALL cover wait states: resp_delay=3, read -> hready low exactly 3 cycles, data valid on the 4th data-phase cycle.
REQ-027 SHALL cover error responses, each with memory unchanged:
- Write to MEM_BASE+DEPTH*4 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1).
- hsize=2 at MEM_BASE+2 -> same two-cycle ERROR.
REQ-028 SHALL cover back-to-back pipelined write 32'hDEADBEEF to MEM_BASE then read MEM_BASE -> 32'hDEADBEEF via forwarding.
REQ-029 SHALL cover reset during WAIT (resp_delay=8): hreset pulsed on 2nd wait cycle -> hready=1 next cycle, target word unmodified.

Source files
------------

// File: rtl/ehl_ahb_pkg.sv
// Shared AHB definitions: transfer/response codes, slave FSM encoding and the
// byte-lane enable decode used by memory slaves.
package ehl_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // Only meaningful for legal (already range/alignment-checked) sizes.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << addr_lsb;
      2'd1:    be = addr_lsb[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ehl_ahb_mem_bytelane.sv
// DEPTH x 32 storage split into four byte-wide lanes, each with its own write
// enable; synchronous write, combinational read.
module ehl_ahb_mem_bytelane #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we[gi]) begin
        r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
      end
    end

    assign o_rdata[gi*8 +: 8] = r_mem[i_raddr];
  end

endmodule

// File: rtl/ehl_ahb_mem_slave.sv
// AHB memory slave: programmable wait states, two-cycle ERROR response,
// byte-lane writes and write-to-read forwarding for back-to-back transfers.
module ehl_ahb_mem_slave
  import ehl_ahb_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [7:0]  resp_delay,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  slave_state_e r_state, w_state_next;
  logic [7:0]       r_cnt;
  logic             r_dp_valid;
  logic             r_dp_write;
  logic [IDX_W-1:0] r_dp_idx;
  logic [3:0]       r_dp_be;
  logic [31:0]      r_hrdata;

  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic             w_misalign;
  logic             w_err;
  logic             w_ready;
  logic             w_accept;
  logic             w_commit;
  logic             w_fwd_hit;
  logic [3:0]       w_be;
  logic [3:0]       w_mem_we;
  logic [31:0]      w_mem_rdata;
  logic [31:0]      w_fwd_data;
  logic             w_unused;

  assign w_unused = htrans[0];

  // A below-base address wraps to a huge offset, so one compare covers both ends.
  assign w_offset   = haddr - MEM_BASE;
  assign w_idx      = w_offset[IDX_W+1:2];
  assign w_misalign = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err      = (hsize > 3'd2) || w_misalign || ({1'b0, w_offset} >= MEM_BYTES);
  assign w_be       = byte_enables(hsize[1:0], haddr[1:0]);

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept = hsel & hready_in & htrans[1] & w_ready & ~hreset;

  // A pending write retires at the edge that ends its last (hready=1) data cycle.
  assign w_commit  = r_dp_valid & r_dp_write & (r_state == ST_IDLE) & ~hreset;
  assign w_mem_we  = w_commit ? r_dp_be : 4'b0000;
  assign w_fwd_hit = w_commit && (r_dp_idx == w_idx);

  ehl_ahb_mem_bytelane #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (hclk),
    .i_we    (w_mem_we),
    .i_waddr (r_dp_idx),
    .i_wdata (hwdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign w_fwd_data[gi*8 +: 8] = (w_fwd_hit && r_dp_be[gi]) ? hwdata[gi*8 +: 8]
                                                              : w_mem_rdata[gi*8 +: 8];
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    hready       = 1'b1;
    hresp        = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (r_state == ST_ERR2) begin
          hresp = HRESP_ERROR;
        end
        if (w_accept && w_err) begin
          w_state_next = ST_ERR1;
        end else if (w_accept && (resp_delay != 8'd0)) begin
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hready = 1'b0;
        if (r_cnt <= 8'd1) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hready       = 1'b0;
        hresp        = HRESP_ERROR;
        w_state_next = ST_ERR2;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Read data is captured at acceptance and simply held through any wait states.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_cnt      <= 8'd0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_be    <= 4'b0000;
      r_hrdata   <= 32'd0;
    end else begin
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_accept) begin
        r_cnt      <= resp_delay;
        r_dp_valid <= ~w_err;
        r_dp_write <= hwrite;
        r_dp_idx   <= w_idx;
        r_dp_be    <= w_be;
        if (!w_err && !hwrite) begin
          r_hrdata <= w_fwd_data;
        end
      end else if (w_ready) begin
        r_dp_valid <= 1'b0;
      end
    end
  end

  assign hrdata = r_hrdata;

endmodule

// File: tb/tb_ehl_ahb_mem_slave.sv
// Scoreboard bench: each address phase pushes its expected response; a negedge
// monitor pops and compares when the data phase completes.
module tb_ehl_ahb_mem_slave;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  typedef struct {
    bit          is_read;
    bit          is_err;
    bit          cancel;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic        hready_in;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [7:0]  resp_delay;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        sb[$];
  logic [31:0] model [int unsigned];

  bit          dp_active = 1'b0;
  int          dp_waits  = 0;
  logic [1:0]  dp_wresp  = 2'd0;

  ehl_ahb_mem_slave #(
    .DEPTH    (DEPTH),
    .MEM_BASE (BASE)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .hready_in  (hready_in),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .resp_delay (resp_delay),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] sz, input logic [1:0] a);
    logic [31:0] m;
    case (sz)
      3'd0:    m = 32'h0000_00FF << (8 * a);
      3'd1:    m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (wd & m);
  endfunction

  // Data-phase monitor; sampled on the falling edge, away from the active edge.
  always @(negedge hclk) begin
    exp_t e;
    if (hreset) begin
      if (dp_active && sb.size() > 0) begin
        e = sb.pop_front();
        $display("xfer addr=%h cancelled by reset after %0d wait cycles", e.addr, dp_waits);
      end
      dp_active = 1'b0;
    end else begin
      if (dp_active && !hready) begin
        dp_waits++;
        dp_wresp = hresp;
      end else if (dp_active && hready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("waits", 32'(dp_waits), 32'(e.waits));
          check("hresp", 32'(hresp), e.is_err ? 32'd1 : 32'd0);
          if (dp_waits > 0) begin
            check("wait_hresp", 32'(dp_wresp), e.is_err ? 32'd1 : 32'd0);
          end
          if (e.is_read && !e.is_err) begin
            check("hrdata", hrdata, e.data);
          end
          $display("xfer %s addr=%h waits=%0d hresp=%0d hrdata=%h", e.is_read ? "RD" : "WR",
                   e.addr, dp_waits, hresp, hrdata);
        end
        dp_active = 1'b0;
      end
      if (hsel && hready_in && htrans[1] && hready) begin
        dp_active = 1'b1;
        dp_waits  = 0;
        dp_wresp  = 2'd0;
      end
    end
  end

  task automatic idle(input int n);
    hsel   = 1'b0;
    htrans = 2'd0;
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Drives one address phase, returns one step after its acceptance edge with
  // write data (if any) on hwdata for the data phase.
  task automatic xfer(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [7:0] dly, input bit err);
    exp_t        e;
    int unsigned widx;
    int          guard;
    widx      = (addr - BASE) >> 2;
    e.is_read = !wr;
    e.is_err  = err;
    e.cancel  = 1'b0;
    e.addr    = addr;
    e.waits   = err ? 1 : int'(dly);
    e.data    = model.exists(widx) ? model[widx] : 32'd0;
    if (wr && !err) begin
      model[widx] = merge(e.data, wd, sz, addr[1:0]);
    end
    sb.push_back(e);
    hsel       = 1'b1;
    htrans     = 2'd2;
    hwrite     = wr;
    hsize      = sz;
    haddr      = addr;
    resp_delay = dly;
    guard      = 0;
    @(negedge hclk);
    while (!hready && guard < 100) begin
      guard++;
      @(negedge hclk);
    end
    if (guard >= 100) begin
      check("accept_timeout", 32'(guard), 32'd0);
    end
    @(posedge hclk);
    #1;
    if (wr) begin
      hwdata = wd;
    end
    hsel   = 1'b0;
    htrans = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    hreset     = 1'b1;
    hsel       = 1'b0;
    hready_in  = 1'b1;
    htrans     = 2'd0;
    hwrite     = 1'b0;
    hsize      = 3'd2;
    haddr      = 32'd0;
    hwdata     = 32'd0;
    resp_delay = 8'd0;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);

    // Word write then back-to-back read
    xfer(1, 3'd2, BASE + 32'h0, 32'h0102_0304, 8'd0, 0);
    xfer(1, 3'd2, BASE + 32'h8, 32'hA5A5_1234, 8'd0, 0);
    xfer(0, 3'd2, BASE + 32'h8, 32'h0, 8'd0, 0);
    idle(2);

    // Byte lane write
    xfer(1, 3'd2, BASE + 32'h4, 32'h1122_3344, 8'd0, 0);
    xfer(1, 3'd0, BASE + 32'h5, 32'h0000_EE00, 8'd0, 0);
    idle(1);
    xfer(0, 3'd2, BASE + 32'h4, 32'h0, 8'd0, 0);
    idle(2);

    // Wait states
    xfer(0, 3'd2, BASE + 32'h8, 32'h0, 8'd3, 0);
    xfer(1, 3'd2, BASE + 32'hC, 32'h0BAD_F00D, 8'd2, 0);
    xfer(0, 3'd2, BASE + 32'hC, 32'h0, 8'd1, 0);
    idle(2);

    // Error responses; the last read proves word 0 was not touched
    xfer(1, 3'd2, BASE + DEPTH * 4, 32'hFFFF_FFFF, 8'd0, 1);
    xfer(1, 3'd2, BASE + 32'h2, 32'hFFFF_FFFF, 8'd0, 1);
    xfer(0, 3'd1, BASE + 32'h1, 32'h0, 8'd0, 1);
    xfer(0, 3'd3, BASE + 32'h0, 32'h0, 8'd0, 1);
    xfer(0, 3'd2, BASE - 32'h4, 32'h0, 8'd0, 1);
    xfer(0, 3'd2, BASE + 32'h0, 32'h0, 8'd0, 0);
    idle(2);

    // Pipelined write->read forwarding, full word and halfword merge
    xfer(1, 3'd2, BASE + 32'h0, 32'hDEAD_BEEF, 8'd0, 0);
    xfer(0, 3'd2, BASE + 32'h0, 32'h0, 8'd0, 0);
    xfer(1, 3'd1, BASE + 32'h2, 32'h7777_0000, 8'd0, 0);
    xfer(0, 3'd2, BASE + 32'h0, 32'h0, 8'd0, 0);
    idle(2);

    // Reset in the second wait cycle of a write cancels it
    xfer(1, 3'd2, BASE + 32'h10, 32'h55AA_55AA, 8'd0, 0);
    idle(2);
    e.is_read = 1'b0;
    e.is_err  = 1'b0;
    e.cancel  = 1'b1;
    e.addr    = BASE + 32'h10;
    e.data    = 32'd0;
    e.waits   = 8;
    sb.push_back(e);
    hsel       = 1'b1;
    htrans     = 2'd2;
    hwrite     = 1'b1;
    hsize      = 3'd2;
    haddr      = BASE + 32'h10;
    resp_delay = 8'd8;
    @(posedge hclk);
    #1;
    hsel   = 1'b0;
    htrans = 2'd0;
    hwdata = 32'hFFFF_FFFF;
    @(posedge hclk);
    #1;
    check("wait_hready", 32'(hready), 32'd0);
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    check("rst_mid_hready", 32'(hready), 32'd1);
    check("rst_mid_hrdata", hrdata, 32'd0);
    xfer(0, 3'd2, BASE + 32'h10, 32'h0, 8'd0, 0);
    idle(4);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
